// File: rtl/stream_dot_mac_pkg.sv
// Shared constants and helpers for the streaming dot-product MAC.
//   sign_extend : replicate bit (from_w-1) of x into all higher bits (64-bit container)
//   len_eff     : dot-product length with zero mapped to one
package stream_dot_mac_pkg;

    localparam int unsigned DEF_LEFT_WIDTH  = 8;
    localparam int unsigned DEF_RIGHT_WIDTH = 8;
    localparam int unsigned DEF_ACC_WIDTH   = 32;
    localparam int unsigned DEF_LEN_WIDTH   = 16;
    localparam int unsigned MAX_WIDTH       = 64;

    function automatic logic [63:0] sign_extend(input logic [63:0] x, input int unsigned from_w);
        logic [63:0] r;
        r = x;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i >= from_w) r[6'(i)] = x[6'(from_w - 1)];
        end
        return r;
    endfunction

    function automatic logic [63:0] len_eff(input logic [63:0] len);
        return (len == 64'd0) ? 64'd1 : len;
    endfunction

endpackage

// File: rtl/stream_dot_mac_mul.sv
// signed_mul_reg: registered signed multiplier stage with valid and a sideband tag.
//   i_en  : capture a new product (wins over i_clr)
//   i_clr : downstream consumed the held product
//   o_valid / o_p / o_tag : held product, its valid and tag
module signed_mul_reg #(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned P_WIDTH   = A_WIDTH + B_WIDTH,
    parameter int unsigned TAG_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic [A_WIDTH-1:0]   i_a,
    input  logic [B_WIDTH-1:0]   i_b,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_valid,
    output logic [P_WIDTH-1:0]   o_p,
    output logic [TAG_WIDTH-1:0] o_tag
);

    logic signed [A_WIDTH-1:0] a_s;
    logic signed [B_WIDTH-1:0] b_s;
    logic signed [P_WIDTH-1:0] prod;

    logic                 valid_d, valid_q;
    logic [P_WIDTH-1:0]   p_d, p_q;
    logic [TAG_WIDTH-1:0] tag_d, tag_q;

    // Operands sign-extended to the product width before multiplying.
    always_comb begin
        a_s  = $signed(i_a);
        b_s  = $signed(i_b);
        prod = P_WIDTH'(a_s) * P_WIDTH'(b_s);
    end

    always_comb begin
        valid_d = valid_q;
        p_d     = p_q;
        tag_d   = tag_q;
        if (i_clr) valid_d = 1'b0;
        if (i_en) begin
            valid_d = 1'b1;
            p_d     = prod;
            tag_d   = i_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            p_q     <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            p_q     <= p_d;
            tag_q   <= tag_d;
        end
    end

    assign o_valid = valid_q;
    assign o_p     = p_q;
    assign o_tag   = tag_q;

endmodule

// File: rtl/stream_dot_mac.sv
// stream_dot_mac: signed dot product of i_len consecutive {left, right} beats.
//   i_valid/i_ready/i_data/i_len : joined operand stream, length sampled on first beat
//   o_valid/o_ready/o_data       : one result per dot product
//   o_count                      : beats accepted so far in the current dot product
module stream_dot_mac
    import stream_dot_mac_pkg::*;
#(
    parameter int unsigned LEFT_WIDTH  = DEF_LEFT_WIDTH,
    parameter int unsigned RIGHT_WIDTH = DEF_RIGHT_WIDTH,
    parameter int unsigned IN_WIDTH    = LEFT_WIDTH + RIGHT_WIDTH,
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int unsigned LEN_WIDTH   = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [LEN_WIDTH-1:0] i_len,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [ACC_WIDTH-1:0] o_data,
    output logic [LEN_WIDTH-1:0] o_count
);

    localparam int unsigned CNT_EXT = LEN_WIDTH + 1;

    if (ACC_WIDTH < IN_WIDTH || ACC_WIDTH > MAX_WIDTH || IN_WIDTH != LEFT_WIDTH + RIGHT_WIDTH) begin : g_bad_width
        $error("stream_dot_mac: invalid width parameters");
    end

    logic                 p_valid, p_last;
    logic [IN_WIDTH-1:0]  p;

    logic                 s2_consume, in_xfer, beat_last;
    logic [LEN_WIDTH-1:0] len_cur;
    logic [ACC_WIDTH-1:0] p_ext, sum;

    logic [ACC_WIDTH-1:0] acc_d, acc_q;
    logic [ACC_WIDTH-1:0] o_data_d, o_data_q;
    logic                 o_valid_d, o_valid_q;
    logic [LEN_WIDTH-1:0] cnt_d, cnt_q;
    logic [LEN_WIDTH-1:0] len_d, len_q;

    signed_mul_reg #(
        .A_WIDTH  (LEFT_WIDTH),
        .B_WIDTH  (RIGHT_WIDTH),
        .P_WIDTH  (IN_WIDTH),
        .TAG_WIDTH(1)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .i_en   (in_xfer),
        .i_clr  (s2_consume),
        .i_a    (i_data[IN_WIDTH-1:RIGHT_WIDTH]),
        .i_b    (i_data[RIGHT_WIDTH-1:0]),
        .i_tag  (beat_last),
        .o_valid(p_valid),
        .o_p    (p),
        .o_tag  (p_last)
    );

    // Handshake, length tracking and accumulation.
    always_comb begin
        // A last product waits only while an older result is still held.
        s2_consume = p_valid && !(p_last && o_valid_q && !o_ready);
        i_ready    = !p_valid || s2_consume;
        in_xfer    = i_valid && i_ready;

        len_cur   = (cnt_q == '0) ? LEN_WIDTH'(len_eff(64'(i_len))) : len_q;
        beat_last = (CNT_EXT'(cnt_q) + CNT_EXT'(1)) == CNT_EXT'(len_cur);

        // acc is zero at the start of every dot product, so no first-beat select.
        p_ext = ACC_WIDTH'(sign_extend(64'(p), IN_WIDTH));
        sum   = acc_q + p_ext;

        acc_d     = acc_q;
        o_data_d  = o_data_q;
        o_valid_d = o_valid_q;
        cnt_d     = cnt_q;
        len_d     = len_q;

        if (o_valid_q && o_ready) o_valid_d = 1'b0;

        if (s2_consume) begin
            if (p_last) begin
                o_data_d  = sum;
                o_valid_d = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d = sum;
            end
        end

        if (in_xfer) begin
            if (cnt_q == '0) len_d = len_cur;
            cnt_d = beat_last ? '0 : cnt_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_count = cnt_q;

    // A held result must not change until it is accepted.
    assert property (@(posedge clk) disable iff (reset)
        (o_valid_q && !o_ready) |=> (o_valid_q && $stable(o_data_q)));

    // Mid-dot-product count always stays below the latched length.
    assert property (@(posedge clk) disable iff (reset)
        (cnt_q != '0) |-> (cnt_q < len_q));

endmodule

// File: tb/tb_stream_dot_mac.sv
module tb_stream_dot_mac;

    logic        clk = 1'b0;
    logic        reset;

    logic        i_valid, i_ready, o_valid, o_ready;
    logic [15:0] i_data, i_len, o_count;
    logic [31:0] o_data;

    logic        i_valid2, i_ready2, o_valid2, o_ready2;
    logic [15:0] i_data2, i_len2, o_count2;
    logic [15:0] o_data2;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] q1[$];
    logic [15:0] q2[$];

    always #5 clk = ~clk;

    stream_dot_mac dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_len(i_len),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_count(o_count)
    );

    stream_dot_mac #(.ACC_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid2), .i_ready(i_ready2), .i_data(i_data2), .i_len(i_len2),
        .o_valid(o_valid2), .o_ready(o_ready2), .o_data(o_data2), .o_count(o_count2)
    );

    // Output transfer logs.
    always @(posedge clk) begin
        if (!reset && o_valid && o_ready) q1.push_back(o_data);
        if (!reset && o_valid2 && o_ready2) q2.push_back(o_data2);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] q1_at(input int i);
        return (q1.size() > i) ? 64'(q1[i]) : {64{1'bx}};
    endfunction

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int l, input int r, input int len);
        bit ok;
        ok      = 1'b0;
        i_valid = 1'b1;
        i_data  = {8'(l), 8'(r)};
        i_len   = 16'(len);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accepted", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        i_valid  = 1'b0; i_data  = '0; i_len  = '0; o_ready  = 1'b1;
        i_valid2 = 1'b0; i_data2 = '0; i_len2 = '0; o_ready2 = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", 64'(o_data), 64'd0);
        check("rst_o_count", 64'(o_count), 64'd0);
        check("rst_i_ready", 64'(i_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // len=4 with mixed signs; later i_len values must be ignored.
        send(1, 1, 4);
        check("len4_count1", 64'(o_count), 64'd1);
        send(2, 3, 1);
        send(-1, 4, 9);
        send(5, -2, 1);
        @(negedge clk);
        check("len4_lat_t1_valid", 64'(o_valid), 64'd0);
        check("len4_count_clr", 64'(o_count), 64'd0);
        @(negedge clk);
        check("len4_lat_t2_valid", 64'(o_valid), 64'd1);
        check("len4_data", 64'(o_data), 64'hFFFF_FFF9);
        @(negedge clk);
        check("len4_valid_clr", 64'(o_valid), 64'd0);
        check("len4_n", 64'(q1.size()), 64'd1);
        check("len4_q0", q1_at(0), 64'hFFFF_FFF9);
        q1.delete();

        // len=1 back-to-back: one result per cycle.
        @(posedge clk); #1;
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                i_valid = 1'b1;
                i_data  = {8'(c + 1), 8'd2};
                i_len   = 16'd1;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 5) check("len1_i_ready", 64'(i_ready), 64'd1);
            if (c >= 2) begin
                check("len1_valid", 64'(o_valid), 64'd1);
                check("len1_data", 64'(o_data), 64'(2 * (c - 1)));
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        @(negedge clk);
        check("len1_n", 64'(q1.size()), 64'd5);
        q1.delete();

        // len=2 under output stall: 4 beats fit, then the pipe blocks.
        @(posedge clk); #1;
        o_ready = 1'b0;
        send(1, 1, 2);
        send(1, 2, 2);
        send(2, 2, 2);
        send(1, 1, 2);
        i_valid = 1'b1;
        i_data  = {8'd3, 8'd3};
        i_len   = 16'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_i_ready", 64'(i_ready), 64'd0);
            check("stall_valid", 64'(o_valid), 64'd1);
            check("stall_data", 64'(o_data), 64'd3);
        end
        @(posedge clk); #1;
        o_ready = 1'b1;
        send(3, 3, 2);
        send(1, 1, 2);
        repeat (4) @(posedge clk);
        #1;
        check("stall_n", 64'(q1.size()), 64'd3);
        check("stall_q0", q1_at(0), 64'd3);
        check("stall_q1", q1_at(1), 64'd5);
        check("stall_q2", q1_at(2), 64'd10);
        q1.delete();

        // len=0 behaves as len=1.
        send(-128, -128, 0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_n", 64'(q1.size()), 64'd1);
        check("len0_q0", q1_at(0), 64'd16384);
        check("len0_count", 64'(o_count), 64'd0);
        q1.delete();

        // 16-bit accumulator wraps silently.
        i_valid2 = 1'b1;
        i_data2  = {8'd127, 8'd127};
        i_len2   = 16'd3;
        repeat (3) begin
            @(negedge clk);
            check("wrap_i_ready", 64'(i_ready2), 64'd1);
            @(posedge clk); #1;
        end
        i_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("wrap_n", 64'(q2.size()), 64'd1);
        check("wrap_q0", (q2.size() > 0) ? 64'(q2[0]) : {64{1'bx}}, 64'hBD03);

        // Reset mid-dot-product discards the partial sum.
        send(1, 1, 4);
        send(1, 1, 4);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_count", 64'(o_count), 64'd0);
        check("mid_rst_valid", 64'(o_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_valid0", 64'(o_valid), 64'd0);
        @(negedge clk);
        check("post_rst_valid1", 64'(o_valid), 64'd0);
        @(posedge clk); #1;
        repeat (4) send(1, 1, 4);
        repeat (3) @(posedge clk);
        #1;
        check("rst_recover_n", 64'(q1.size()), 64'd1);
        check("rst_recover_q0", q1_at(0), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
